// File: rtl/thumb_pc_sequencer.sv
// Program-counter sequencer for the single-cycle Thumb-subset core: conditional/unconditional
// branches, BL prefix/suffix pairing, LR write port and the one-cycle fetch flush.
module thumb_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic [3:0]  flags,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] lr_wdata,
  output logic        lr_we,
  output logic        branch_taken,
  output logic        flush,
  output logic        seq_err
);

  typedef enum logic [1:0] {RUN, BL_WAIT, FLUSH_S} state_t;

  state_t      state, state_nxt;
  logic [31:0] bl_tmp, bl_tmp_nxt, pc_nxt, lr_wdata_nxt;
  logic        lr_we_nxt, flush_nxt, seq_err_nxt;

  logic        n, z, c, v;
  logic        is_bcond, is_b, is_pre, is_suf, cond_pass;
  logic [31:0] pc_seq, pc_4, off8, off11, pre_off, suf_off;

  assign {n, z, c, v} = flags;
  assign pc_seq   = pc + 32'd2;
  assign pc_4     = pc + 32'd4;
  assign is_bcond = (instr[15:12] == 4'b1101) && (instr[11:8] <= 4'hD);
  assign is_b     = (instr[15:11] == 5'b11100);
  assign is_pre   = (instr[15:11] == 5'b11110);
  assign is_suf   = (instr[15:11] == 5'b11111);
  assign off8     = {{23{instr[7]}}, instr[7:0], 1'b0};
  assign off11    = {{20{instr[10]}}, instr[10:0], 1'b0};
  assign pre_off  = {{9{instr[10]}}, instr[10:0], 12'd0};
  assign suf_off  = {20'd0, instr[10:0], 1'b0};

  always_comb begin
    cond_pass = 1'b0;
    case (instr[11:8])
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt    = state;
    pc_nxt       = pc;
    bl_tmp_nxt   = bl_tmp;
    lr_wdata_nxt = lr_wdata;
    lr_we_nxt    = 1'b0;
    flush_nxt    = 1'b0;
    seq_err_nxt  = 1'b0;
    branch_taken = 1'b0;

    if (state == FLUSH_S) begin
      state_nxt = RUN;
    end else if (instr_valid && !stall) begin
      if (is_suf && state == BL_WAIT) begin
        branch_taken = 1'b1;
        pc_nxt       = bl_tmp + suf_off;
        bl_tmp_nxt   = '0;
        lr_we_nxt    = 1'b1;
        lr_wdata_nxt = pc_seq | 32'd1;
      end else begin
        // Anything other than a suffix in BL_WAIT, or a suffix in RUN, breaks the pair.
        seq_err_nxt = (state == BL_WAIT) || is_suf;
        if (state == BL_WAIT) bl_tmp_nxt = '0;
        state_nxt = RUN;
        pc_nxt    = pc_seq;
        if (is_pre) begin
          bl_tmp_nxt = pc_4 + pre_off;
          state_nxt  = BL_WAIT;
        end else if (is_b) begin
          branch_taken = 1'b1;
          pc_nxt       = pc_4 + off11;
        end else if (is_bcond && cond_pass) begin
          branch_taken = 1'b1;
          pc_nxt       = pc_4 + off8;
        end
      end
      if (branch_taken) begin
        state_nxt = FLUSH_S;
        flush_nxt = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      bl_tmp   <= '0;
      lr_wdata <= '0;
      lr_we    <= 1'b0;
      flush    <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      bl_tmp   <= bl_tmp_nxt;
      lr_wdata <= lr_wdata_nxt;
      lr_we    <= lr_we_nxt;
      flush    <= flush_nxt;
      seq_err  <= seq_err_nxt;
    end
  end

endmodule

// File: tb/tb_thumb_pc_sequencer.sv
// Directed bench for thumb_pc_sequencer: expected post-edge outputs are queued when each
// instruction is driven and popped for comparison once the edge has happened.
module tb_thumb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic [3:0]  flags;
  logic        stall;
  logic [31:0] pc, lr_wdata;
  logic        lr_we, branch_taken, flush, seq_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        lr_we;
    logic [31:0] lr_wdata;
    logic        seq_err;
  } exp_t;

  exp_t sb[$];

  localparam logic [3:0] FZ = 4'b0100;
  localparam logic [3:0] FN = 4'b1000;
  localparam logic [3:0] F0 = 4'b0000;

  thumb_pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .flags        (flags),
    .stall        (stall),
    .pc           (pc),
    .lr_wdata     (lr_wdata),
    .lr_we        (lr_we),
    .branch_taken (branch_taken),
    .flush        (flush),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive, check the combinational decision, then the registered result.
  task automatic step(input string tag, input logic v, input logic s, input logic [15:0] i,
                      input logic [3:0] f, input logic ebt, input logic [31:0] epc,
                      input logic efl, input logic elw, input logic [31:0] elr, input logic ese);
    exp_t e;
    instr_valid = v;
    stall       = s;
    instr       = i;
    flags       = f;
    #1;
    chk({tag, ".branch_taken"}, 32'(branch_taken), 32'(ebt));
    sb.push_back('{pc: epc, flush: efl, lr_we: elw, lr_wdata: elr, seq_err: ese});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".flush"}, 32'(flush), 32'(e.flush));
    chk({tag, ".lr_we"}, 32'(lr_we), 32'(e.lr_we));
    chk({tag, ".seq_err"}, 32'(seq_err), 32'(e.seq_err));
    if (e.lr_we) chk({tag, ".lr_wdata"}, lr_wdata, e.lr_wdata);
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h46C0;
    flags       = F0;
    stall       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.pc", pc, 32'h0);
    chk("rst.lr_wdata", lr_wdata, 32'h0);
    chk("rst.lr_we", 32'(lr_we), 32'h0);
    chk("rst.flush", 32'(flush), 32'h0);
    chk("rst.seq_err", 32'(seq_err), 32'h0);
    rst_n = 1'b1;

    //   tag          v     s     instr     flags bt    pc             fl    lw    lr            se
    step("nop0",      1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_0002, 1'b0, 1'b0, 32'h0,        1'b0);
    step("nop1",      1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'h0,        1'b0);
    step("nop2",      1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_0006, 1'b0, 1'b0, 32'h0,        1'b0);
    step("b_100",     1'b1, 1'b0, 16'hE07B, F0,   1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0,        1'b0);
    step("fl0",       1'b1, 1'b0, 16'hE7FF, F0,   1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0,        1'b0);
    step("beq_t",     1'b1, 1'b0, 16'hD0FE, FZ,   1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0,        1'b0);
    step("fl1",       1'b1, 1'b0, 16'hD0FE, FZ,   1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0,        1'b0);
    step("beq_nt",    1'b1, 1'b0, 16'hD0FE, F0,   1'b0, 32'h0000_0102, 1'b0, 1'b0, 32'h0,        1'b0);
    step("cond_e",    1'b1, 1'b0, 16'hDEFE, F0,   1'b0, 32'h0000_0104, 1'b0, 1'b0, 32'h0,        1'b0);
    step("bgt_nt",    1'b1, 1'b0, 16'hDCFE, FN,   1'b0, 32'h0000_0106, 1'b0, 1'b0, 32'h0,        1'b0);
    step("blt_t",     1'b1, 1'b0, 16'hDBFE, FN,   1'b1, 32'h0000_0106, 1'b1, 1'b0, 32'h0,        1'b0);
    step("fl2",       1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_0106, 1'b0, 1'b0, 32'h0,        1'b0);
    step("b_200",     1'b1, 1'b0, 16'hE07B, F0,   1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0,        1'b0);
    step("fl3",       1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_0200, 1'b0, 1'b0, 32'h0,        1'b0);
    step("b_m2",      1'b1, 1'b0, 16'hE7FF, F0,   1'b1, 32'h0000_0202, 1'b1, 1'b0, 32'h0,        1'b0);
    step("fl_stall",  1'b1, 1'b1, 16'h46C0, F0,   1'b0, 32'h0000_0202, 1'b0, 1'b0, 32'h0,        1'b0);
    step("stall",     1'b1, 1'b1, 16'hE7FF, F0,   1'b0, 32'h0000_0202, 1'b0, 1'b0, 32'h0,        1'b0);
    step("invalid",   1'b0, 1'b0, 16'hE7FF, F0,   1'b0, 32'h0000_0202, 1'b0, 1'b0, 32'h0,        1'b0);
    step("b_far1",    1'b1, 1'b0, 16'hE3FF, F0,   1'b1, 32'h0000_0A04, 1'b1, 1'b0, 32'h0,        1'b0);
    step("fl4",       1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_0A04, 1'b0, 1'b0, 32'h0,        1'b0);
    step("b_far2",    1'b1, 1'b0, 16'hE2FC, F0,   1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'h0,        1'b0);
    step("fl5",       1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_1000, 1'b0, 1'b0, 32'h0,        1'b0);
    step("bl_pre",    1'b1, 1'b0, 16'hF001, F0,   1'b0, 32'h0000_1002, 1'b0, 1'b0, 32'h0,        1'b0);
    step("bl_suf",    1'b1, 1'b0, 16'hF810, F0,   1'b1, 32'h0000_2024, 1'b1, 1'b1, 32'h0000_1005, 1'b0);
    step("fl6",       1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_2024, 1'b0, 1'b0, 32'h0,        1'b0);
    step("bl2_pre",   1'b1, 1'b0, 16'hF7FF, F0,   1'b0, 32'h0000_2026, 1'b0, 1'b0, 32'h0,        1'b0);
    for (int k = 0; k < 3; k++)
      step("bl2_stall", 1'b1, 1'b1, 16'hF810, F0, 1'b0, 32'h0000_2026, 1'b0, 1'b0, 32'h0,        1'b0);
    step("bl2_suf",   1'b1, 1'b0, 16'hF810, F0,   1'b1, 32'h0000_1048, 1'b1, 1'b1, 32'h0000_2029, 1'b0);
    step("fl7",       1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_1048, 1'b0, 1'b0, 32'h0,        1'b0);
    step("pre_nop",   1'b1, 1'b0, 16'hF000, F0,   1'b0, 32'h0000_104A, 1'b0, 1'b0, 32'h0,        1'b0);
    step("nop_err",   1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_104C, 1'b0, 1'b0, 32'h0,        1'b1);
    step("nop_ok",    1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_104E, 1'b0, 1'b0, 32'h0,        1'b0);
    step("lone_suf",  1'b1, 1'b0, 16'hF810, F0,   1'b0, 32'h0000_1050, 1'b0, 1'b0, 32'h0,        1'b1);
    step("pre_a",     1'b1, 1'b0, 16'hF000, F0,   1'b0, 32'h0000_1052, 1'b0, 1'b0, 32'h0,        1'b0);
    step("pre_b",     1'b1, 1'b0, 16'hF000, F0,   1'b0, 32'h0000_1054, 1'b0, 1'b0, 32'h0,        1'b1);
    step("suf_b",     1'b1, 1'b0, 16'hF801, F0,   1'b1, 32'h0000_1058, 1'b1, 1'b1, 32'h0000_1057, 1'b0);
    step("fl8",       1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_1058, 1'b0, 1'b0, 32'h0,        1'b0);
    step("pre_rst",   1'b1, 1'b0, 16'hF000, F0,   1'b0, 32'h0000_105A, 1'b0, 1'b0, 32'h0,        1'b0);

    // Asynchronous reset in the middle of a BL pair.
    #3 rst_n = 1'b0;
    #1;
    chk("arst.pc", pc, 32'h0);
    chk("arst.lr_we", 32'(lr_we), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step("suf_after_rst", 1'b1, 1'b0, 16'hF810, F0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 32'h0,      1'b1);
    step("b_wrap",    1'b1, 1'b0, 16'hE7FC, F0,   1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0,        1'b0);
    step("fl9",       1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0,        1'b0);
    step("wrap",      1'b1, 1'b0, 16'h46C0, F0,   1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,        1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thumb_pc_sequencer.md
# thumb_pc_sequencer

Program-counter sequencer for the single-cycle Thumb-subset core. It consumes each decoded 16-bit instruction, evaluates branch conditions against the NZCV flags, and forms branch targets from the sign-extended, halfword-scaled IMM8/IMM11 fields. It stitches BL prefix/suffix halfword pairs into one call and drives PC, the LR write port, and the fetch flush. It sits between the fetch stage and the register file, and is the only writer of PC.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CLK, in, 1, single clock; all state updates on the rising edge.
- RST_N, in, 1, asynchronous, active-low reset.
- INSTR_VALID, in, 1, INSTR holds the instruction located at PC.
- INSTR, in, 16, current Thumb instruction.
- FLAGS, in, 4, {N,Z,C,V} as committed before this instruction.
- STALL, in, 1, freezes all state; no instruction is consumed.
- PC, out, 32, address of the instruction to fetch or execute; registered.
- LR_WDATA, out, 32, link value for the register file.
- LR_WE, out, 1, one-cycle LR write strobe; registered.
- BRANCH_TAKEN, out, 1, combinational; current instruction redirects PC.
- FLUSH, out, 1, registered one-cycle pulse; fetch must discard its in-flight halfword.
- SEQ_ERR, out, 1, registered one-cycle pulse on an unpaired BL half.

## Operation

An instruction is consumed when INSTR_VALID=1, STALL=0, and state≠FLUSH. All sums are 32-bit modulo 2^32, with no overflow detection. sext() sign-extends to 32 bits.

- Conditional B, INSTR[15:12]=4'b1101 and cond=INSTR[11:8]≤4'hD:
  - target = PC+4+(sext(INSTR[7:0])<<1).
  - Conditions:
    - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
    - HI C&!Z, LS !C|Z.
    - GE N==V, LT N!=V.
    - GT !Z&(N==V), LE Z|(N!=V).
  - cond 4'hE/4'hF is not a branch; the instruction is sequential.
- B, INSTR[15:11]=5'b11100: always taken; target = PC+4+(sext(INSTR[10:0])<<1).
- BL prefix, INSTR[15:11]=5'b11110:
  - BL_TMP ← PC+4+(sext(INSTR[10:0])<<12).
  - PC ← PC+2; go to BL_WAIT.
- BL suffix, INSTR[15:11]=5'b11111, in BL_WAIT:
  - Taken; target = BL_TMP+({21'd0,INSTR[10:0]}<<1).
  - LR_WDATA = (PC+2)|1; LR_WE pulses.
- Any other instruction: PC ← PC+2.
- Taken branch: PC ← target; go to FLUSH.

FSM states:

- RUN: prefix → BL_WAIT; taken branch → FLUSH; otherwise stay.
- BL_WAIT: suffix → FLUSH.
  - Any other instruction: SEQ_ERR pulses, BL_TMP is discarded, the instruction executes as in RUN, and the next state follows RUN rules (a second prefix reloads BL_TMP and stays in BL_WAIT).
- FLUSH: FLUSH=1 for exactly one cycle; INSTR ignored; next state is RUN unconditionally, and STALL does not extend it.

Other rules:

- A suffix seen in RUN is treated as sequential (PC+2) and pulses SEQ_ERR.
- STALL=1 or INSTR_VALID=0 in RUN/BL_WAIT: PC, state, and BL_TMP hold; LR_WE=0.

## Timing

- Reset values (async on RST_N=0): PC=RESET_PC, state=RUN, BL_TMP=0, LR_WDATA=0, LR_WE=0, FLUSH=0, SEQ_ERR=0.
- Decision latency: 0 cycles. BRANCH_TAKEN is valid in the consuming cycle; PC updates on the next edge.
- LR_WE/LR_WDATA, FLUSH, and SEQ_ERR are registered and valid in the cycle after consumption. LR_WE and FLUSH assert in the same cycle.
- Taken-branch throughput: 2 cycles (consume, then FLUSH). Sequential throughput: 1 instruction per cycle.
- A reset mid-pair (in BL_WAIT) discards BL_TMP; no LR write occurs.
- PC wraps 32'hFFFF_FFFE+2 → 32'h0000_0000 silently.

## Test plan

- Reset with RESET_PC=0, then 3 valid NOPs (INSTR=16'h46C0) → PC 0x0, 0x2, 0x4, 0x6; FLUSH/LR_WE stay 0.
- PC=0x100, INSTR=16'hD0FE (BEQ −4):
  - Z=1 → BRANCH_TAKEN=1, next PC=0x100, FLUSH=1 one cycle, and the instruction in the FLUSH cycle is ignored.
  - Z=0 → PC=0x102.
- PC=0x200, INSTR=16'hE7FF (B −2) → PC=0x202 next cycle, FLUSH pulses.
- PC=0x1000, prefix 16'hF001, then suffix 16'h F810 at 0x1002 → PC=0x2024, LR_WDATA=0x1005, LR_WE=1 for one cycle.
  - Repeat with STALL=1 for 3 cycles between the halves → same result.
- Prefix followed by a NOP → SEQ_ERR=1 one cycle, PC advances +2 each.
  - A lone suffix in RUN → SEQ_ERR=1, PC+2, LR_WE=0.
- RST_N dropped asynchronously in BL_WAIT → PC=RESET_PC immediately; a following suffix → SEQ_ERR, no LR write.
